wb_master_bridge: RTL

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_master_bridge.sv | 107 ++++++++++
 1 files changed

// File: rtl/wb_master_bridge.sv
// CPU-side 16-bit request port bridged onto a 32-bit Wishbone classic master.
// A single transaction runs at a time, with a per-transaction wait-cycle timeout.
module wb_master_bridge #(
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [15:0] cpu_addr_i,
    input  logic [15:0] cpu_wdata_i,
    input  logic [1:0]  cpu_be_i,
    output logic        cpu_busy_o,
    output logic        cpu_done_o,
    output logic        cpu_err_o,
    output logic [15:0] cpu_rdata_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       hi_half;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            hi_half     <= 1'b0;
            cpu_busy_o  <= 1'b0;
            cpu_done_o  <= 1'b0;
            cpu_err_o   <= 1'b0;
            cpu_rdata_o <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i) begin
                        // Bus-side fields are latched here and held for the whole cycle
                        hi_half    <= cpu_addr_i[0];
                        wbm_adr_o  <= {BASE_ADDR[31:17], cpu_addr_i[15:1], 2'b00};
                        wbm_dat_o  <= cpu_addr_i[0] ? {cpu_wdata_i, 16'h0000}
                                                    : {16'h0000, cpu_wdata_i};
                        wbm_sel_o  <= cpu_addr_i[0] ? {cpu_be_i, 2'b00}
                                                    : {2'b00, cpu_be_i};
                        wbm_we_o   <= cpu_we_i;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        cpu_busy_o <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    // Ack takes priority, so an ack on the expiry edge still completes cleanly
                    if (wbm_ack_i) begin
                        wbm_cyc_o  <= 1'b0;
                        wbm_stb_o  <= 1'b0;
                        cpu_done_o <= 1'b1;
                        cpu_err_o  <= 1'b0;
                        if (!wbm_we_o) begin
                            cpu_rdata_o <= hi_half ? wbm_dat_i[31:16] : wbm_dat_i[15:0];
                        end
                        state <= RESP;
                    end else if (wait_cnt == TIMEOUT_CYCLES) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        cpu_done_o  <= 1'b1;
                        cpu_err_o   <= 1'b1;
                        cpu_rdata_o <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    cpu_done_o <= 1'b0;
                    cpu_err_o  <= 1'b0;
                    cpu_busy_o <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
